// File: rtl/flag_bank.sv
`default_nettype none
// ============================================================================
// flag_bank : NUM_FLAGS pulse/sticky status flags, saturating per-channel event
//             counters and a request/acknowledge bulk-clear handshake.
//             Optional first-event capture enabled by macro FLAG_FIRST_EN.
// Revision  : 1.0  initial release
// ============================================================================
module flag_bank #(
  parameter int NUM_FLAGS = 4,
  parameter int CNT_W     = 8
) (
  input  logic                       CLK,
  input  logic                       init_n,
  input  logic [NUM_FLAGS-1:0]       flag_write,
  input  logic [NUM_FLAGS-1:0]       flag_in,
  input  logic [NUM_FLAGS-1:0]       sticky,
  input  logic                       clr_req,
  input  logic [NUM_FLAGS-1:0]       clr_mask,
  output logic                       clr_ack,
  output logic [NUM_FLAGS-1:0]       flag_out,
  output logic                       any_flag,
  output logic [NUM_FLAGS*CNT_W-1:0] evt_cnt,
`ifdef FLAG_FIRST_EN
  output logic                       first_valid,
  output logic [((NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1)-1:0] first_id,
`endif
  output logic [NUM_FLAGS-1:0]       cnt_sat
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic [NUM_FLAGS-1:0] w_ev;
  logic [NUM_FLAGS-1:0] w_clr_hit;

  assign w_ev      = flag_write & flag_in;
  assign w_accept  = (r_state == S_IDLE) && clr_req;
  assign w_clr_hit = {NUM_FLAGS{w_accept}} & clr_mask;
  assign clr_ack   = (r_state == S_ACK);
  assign any_flag  = |flag_out;

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // A held request is honoured once; WAIT absorbs it until clr_req drops.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (clr_req) w_state_next = S_ACK;
      S_ACK:   w_state_next = clr_req ? S_WAIT : S_IDLE;
      S_WAIT:  if (!clr_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_chan
    logic             r_flag;
    logic             w_flag_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sat;

    always_comb begin
      w_cnt_next = r_cnt;
      if (w_ev[gi] && w_clr_hit[gi])   w_cnt_next = CNT_W'(1);
      else if (w_clr_hit[gi])          w_cnt_next = '0;
      else if (w_ev[gi] && (r_cnt != C_CNT_MAX)) w_cnt_next = r_cnt + CNT_W'(1);

      if (sticky[gi]) w_flag_next = w_ev[gi] | (r_flag & ~w_clr_hit[gi]);
      else            w_flag_next = flag_write[gi] & flag_in[gi];
    end

    always_ff @(posedge CLK or negedge init_n) begin
      if (!init_n) begin
        r_flag <= 1'b0;
        r_cnt  <= '0;
        r_sat  <= 1'b0;
      end else begin
        r_flag <= w_flag_next;
        r_cnt  <= w_cnt_next;
        r_sat  <= (w_cnt_next == C_CNT_MAX);
      end
    end

    assign flag_out[gi]                 = r_flag;
    assign evt_cnt[gi*CNT_W +: CNT_W]   = r_cnt;
    assign cnt_sat[gi]                  = r_sat;
  end

`ifdef FLAG_FIRST_EN
  localparam int FID_W = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;

  logic             r_first_valid;
  logic [FID_W-1:0] r_first_id;
  logic [FID_W-1:0] w_first_enc;

  // Descending scan leaves the lowest set index in the encoder.
  always_comb begin
    w_first_enc = '0;
    for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
      if (w_ev[i]) w_first_enc = FID_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_first_valid <= 1'b0;
      r_first_id    <= '0;
    end else if (w_accept) begin
      r_first_valid <= |w_ev;
      r_first_id    <= (|w_ev) ? w_first_enc : '0;
    end else if (!r_first_valid && (|w_ev)) begin
      r_first_valid <= 1'b1;
      r_first_id    <= w_first_enc;
    end
  end

  assign first_valid = r_first_valid;
  assign first_id    = r_first_id;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flag_bank.sv
`default_nettype none
// ============================================================================
// tb_flag_bank : directed self-checking bench for flag_bank (CNT_W=8 main
//                instance plus a CNT_W=2 instance for saturation).
// Revision     : 1.0  initial release
// ============================================================================
module tb_flag_bank;

  logic       CLK = 1'b0;
  logic       init_n;
  logic [3:0] flag_write, flag_in, sticky, clr_mask;
  logic       clr_req;

  logic        clr_ack, any_flag, s_clr_ack, s_any_flag;
  logic [3:0]  flag_out, cnt_sat, s_flag_out, s_cnt_sat;
  logic [31:0] evt_cnt;
  logic [7:0]  s_evt_cnt;
`ifdef FLAG_FIRST_EN
  logic       first_valid, s_first_valid;
  logic [1:0] first_id, s_first_id;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  flag_bank #(.NUM_FLAGS(4), .CNT_W(8)) u_dut (
    .CLK(CLK), .init_n(init_n), .flag_write(flag_write), .flag_in(flag_in),
    .sticky(sticky), .clr_req(clr_req), .clr_mask(clr_mask), .clr_ack(clr_ack),
    .flag_out(flag_out), .any_flag(any_flag), .evt_cnt(evt_cnt),
`ifdef FLAG_FIRST_EN
    .first_valid(first_valid), .first_id(first_id),
`endif
    .cnt_sat(cnt_sat)
  );

  flag_bank #(.NUM_FLAGS(4), .CNT_W(2)) u_sat (
    .CLK(CLK), .init_n(init_n), .flag_write(flag_write), .flag_in(flag_in),
    .sticky(sticky), .clr_req(clr_req), .clr_mask(clr_mask), .clr_ack(s_clr_ack),
    .flag_out(s_flag_out), .any_flag(s_any_flag), .evt_cnt(s_evt_cnt),
`ifdef FLAG_FIRST_EN
    .first_valid(s_first_valid), .first_id(s_first_id),
`endif
    .cnt_sat(s_cnt_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] cnt(input int ch);
    return evt_cnt[ch*8 +: 8];
  endfunction

  initial begin
    init_n = 1'b0; flag_write = '0; flag_in = '0; sticky = '0;
    clr_req = 1'b0; clr_mask = '0;
    #3;
    check("rst_flag", 32'(flag_out), 32'h0);
    check("rst_cnt", evt_cnt, 32'h0);
    check("rst_sat", 32'(cnt_sat), 32'h0);
    check("rst_ack", 32'(clr_ack), 32'h0);
    check("rst_any", 32'(any_flag), 32'h0);
`ifdef FLAG_FIRST_EN
    check("rst_fv", 32'(first_valid), 32'h0);
`endif
    step();
    init_n = 1'b1;
    step();

    // Pulse mode
    flag_write = 4'b0001; flag_in = 4'b0001;
    step();
    check("pulse_flag", 32'(flag_out), 32'h1);
    check("pulse_any", 32'(any_flag), 32'h1);
    check("pulse_cnt0", 32'(cnt(0)), 32'h1);
    flag_write = '0; flag_in = '0;
    step();
    check("pulse_flag_drop", 32'(flag_out), 32'h0);
    check("pulse_any_drop", 32'(any_flag), 32'h0);
    check("pulse_cnt0_hold", 32'(cnt(0)), 32'h1);

    // Sticky hold, write-0 does not clear, masked clear
    sticky = 4'b0010; flag_write = 4'b0010; flag_in = 4'b0010;
    step();
    flag_write = '0; flag_in = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) flag_write = 4'b0010;
      if (k == 5) flag_write = '0;
      step();
      check($sformatf("sticky_hold%0d", k), 32'(flag_out[1]), 32'h1);
    end
    check("sticky_cnt1", 32'(cnt(1)), 32'h1);
    clr_req = 1'b1; clr_mask = 4'b0010;
    step();
    check("clr_flag1", 32'(flag_out[1]), 32'h0);
    check("clr_cnt1", 32'(cnt(1)), 32'h0);
    check("clr_cnt0_kept", 32'(cnt(0)), 32'h1);
    check("clr_ack_hi", 32'(clr_ack), 32'h1);
    clr_req = 1'b0; clr_mask = '0;
    step();
    check("clr_ack_lo", 32'(clr_ack), 32'h0);

    // Set vs clear collision on sticky ch2
    sticky = 4'b0100; flag_write = 4'b0100; flag_in = 4'b0100;
    repeat (5) step();
    check("coll_pre_cnt2", 32'(cnt(2)), 32'h5);
    clr_req = 1'b1; clr_mask = 4'b0100;
    step();
    check("coll_flag2", 32'(flag_out[2]), 32'h1);
    check("coll_cnt2", 32'(cnt(2)), 32'h1);
    check("coll_ack", 32'(clr_ack), 32'h1);
    clr_req = 1'b0; clr_mask = '0; flag_write = '0; flag_in = '0;
    step();
    check("coll_ack_lo", 32'(clr_ack), 32'h0);
    check("coll_flag2_hold", 32'(flag_out[2]), 32'h1);

    // Saturation on the CNT_W=2 instance, ch3
    sticky = 4'b0000; flag_write = 4'b1000; flag_in = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("sat_cnt3_%0d", k), 32'(s_evt_cnt[7:6]), (k < 3) ? 32'(k + 1) : 32'd3);
      check($sformatf("sat_flag3_%0d", k), 32'(s_cnt_sat[3]), (k >= 2) ? 32'h1 : 32'h0);
    end
    check("sat_main_cnt3", 32'(cnt(3)), 32'h5);
    check("sat_main_nosat", 32'(cnt_sat[3]), 32'h0);
    flag_write = '0; flag_in = '0;
    step();

    // Held request with continuous events on ch0
    sticky = 4'b0001; flag_write = 4'b0001; flag_in = 4'b0001;
    clr_req = 1'b1; clr_mask = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("held_cnt0_%0d", k), 32'(cnt(0)), 32'(k + 1));
      check($sformatf("held_ack_%0d", k), 32'(clr_ack), (k == 0) ? 32'h1 : 32'h0);
    end
    clr_req = 1'b0;
    step();
    check("held_drop_cnt0", 32'(cnt(0)), 32'h7);
    check("held_drop_ack", 32'(clr_ack), 32'h0);
    clr_req = 1'b1;
    step();
    check("held_re_cnt0", 32'(cnt(0)), 32'h1);
    check("held_re_ack", 32'(clr_ack), 32'h1);
    clr_req = 1'b0;
    step();
    check("held_re_cnt0b", 32'(cnt(0)), 32'h2);
    check("held_re_ack_lo", 32'(clr_ack), 32'h0);
    flag_write = '0; flag_in = '0;
    step();

    // Asynchronous reset while in ACK
    clr_req = 1'b1; clr_mask = 4'b0001;
    step();
    check("ar_ack_pre", 32'(clr_ack), 32'h1);
    #2;
    init_n = 1'b0;
    #1;
    check("ar_ack", 32'(clr_ack), 32'h0);
    check("ar_flag", 32'(flag_out), 32'h0);
    check("ar_cnt", evt_cnt, 32'h0);
    check("ar_sat_s", 32'(s_cnt_sat), 32'h0);
    clr_req = 1'b0; clr_mask = '0;
    step();
    init_n = 1'b1;
    step();

`ifdef FLAG_FIRST_EN
    flag_write = 4'b1010; flag_in = 4'b1010;
    step();
    check("first_valid", 32'(first_valid), 32'h1);
    check("first_id", 32'(first_id), 32'h1);
    flag_write = 4'b0100; flag_in = 4'b0100;
    step();
    check("first_id_hold", 32'(first_id), 32'h1);
    flag_write = '0; flag_in = '0; clr_req = 1'b1; clr_mask = '0;
    step();
    check("first_clr_v", 32'(first_valid), 32'h0);
    check("first_clr_id", 32'(first_id), 32'h0);
    clr_req = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flag_bank.md
Name: flag_bank

Overview:
- Parametrised multi-channel successor to the single-bit overflow/comparison flag register.
- Holds NUM_FLAGS status flags, each in legacy pulse mode or sticky mode, with a saturating per-channel event counter.
- Has a request/acknowledge bulk-clear handshake.
- Sits beside the ALU/compare logic; the controller and debug readout consume flag_out and evt_cnt.

Parameters:
NUM_FLAGS, 4, number of flag channels (1..16)
CNT_W, 8, width of each per-channel event counter (2..16)

Ports:
CLK  in  1  clock, all state updates on posedge
init_n  in  1  asynchronous active-low reset
flag_write  in  NUM_FLAGS  per-channel write enable
flag_in  in  NUM_FLAGS  per-channel flag value
sticky  in  NUM_FLAGS  per-channel mode: 1 = sticky, 0 = pulse (legacy)
clr_req  in  1  bulk clear request (level)
clr_mask  in  NUM_FLAGS  channels cleared by the request
clr_ack  out  1  one-cycle clear acknowledge
flag_out  out  NUM_FLAGS  registered flags
any_flag  out  1  combinational OR of flag_out
evt_cnt  out  NUM_FLAGS*CNT_W  counters; channel i at bits [i*CNT_W +: CNT_W]
cnt_sat  out  NUM_FLAGS  counter i at max value (registered)

Behaviour:
- Reset (init_n low, asynchronous): flag_out, evt_cnt, cnt_sat, clr_ack = 0; FSM = IDLE. Release is synchronous to CLK.
- Event: ev[i] = flag_write[i] & flag_in[i].
- Clear hit: clr_hit[i] = (FSM in IDLE) & clr_req & clr_mask[i]. Evaluated combinationally; takes effect at the same edge the FSM leaves IDLE.
- Pulse channel (sticky[i]=0): flag_out[i] <= flag_write[i] ? flag_in[i] : 0. This is exact legacy behaviour, one-cycle latency. clr_hit has no extra effect on the flag.
- Sticky channel (sticky[i]=1): flag_out[i] <= ev[i] | (flag_out[i] & ~clr_hit[i]).
  - Set wins over simultaneous clear.
  - flag_write with flag_in=0 does not clear a sticky flag.
- Mode change: the new sticky[i] value applies from the next edge. No state is lost; the counter is unaffected.
- Counter, both modes:
  - ev & clr_hit -> 1
  - clr_hit only -> 0
  - ev only -> cnt+1, saturating at 2^CNT_W-1
  - otherwise hold
  - cnt_sat[i] is registered alongside the counter: 1 iff the next counter value == 2^CNT_W-1.
- Clear FSM:
  - IDLE: clr_req=1 -> ACK, clear applied at this edge.
  - ACK: clr_ack=1 for exactly this cycle. Next state is IDLE if clr_req=0, else WAIT.
  - WAIT: clr_ack=0, no clear. Go to IDLE when clr_req=0.
  - A held request clears once only. A new clear needs clr_req low for at least one cycle.
  - clr_ack is a Moore output (registered state decode): it is high the cycle after the request is accepted.
- clr_mask is sampled only at the accepting edge; changes in ACK/WAIT are ignored.
- Reset mid-handshake: FSM returns to IDLE and clr_ack drops immediately (asynchronously).

Optional Feature:
- Macro FLAG_FIRST_EN.
- Defined: adds outputs first_valid (1 bit) and first_id ($clog2(NUM_FLAGS) bits, minimum 1).
  - On the first edge with any ev while first_valid=0, latch first_valid=1 and first_id = lowest index with ev set.
  - Hold until reset, or until a clear is accepted. An accepted clear zeroes both unless an ev occurs on that same edge, in which case recapture.
  - Reset value is 0 for both.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/pulse: NUM_FLAGS=4, sticky=0000; write flag_write=0001, flag_in=0001 for 1 cycle -> flag_out=0001 next cycle, then 0000; evt_cnt[0]=1; any_flag pulses 1 cycle.
- Sticky hold and clear: sticky=0010, one event on ch1 -> flag_out[1] stays 1 for 10 cycles. clr_req=1 with clr_mask=0010 for 1 cycle -> flag_out[1]=0 next cycle, evt_cnt[1]=0, clr_ack high exactly 1 cycle.
- Set vs clear collision: sticky ch2 with evt_cnt[2]=5; ev on ch2 in the same cycle a clear is accepted with mask=0100 -> flag_out[2]=1, evt_cnt[2]=1.
- Saturation: CNT_W=2, 5 consecutive events on ch3 -> evt_cnt[3] sequence 1,2,3,3,3; cnt_sat[3]=1 from the third event onward.
- Held request: clr_req high for 6 cycles, events on ch0 throughout -> exactly one clear, one clr_ack pulse, and counter counts up after the clear. Drop clr_req 1 cycle then reassert -> second clear and second ack.
- Async reset mid-handshake: assert init_n=0 during ACK -> clr_ack, flag_out, evt_cnt = 0 without waiting for CLK. With FLAG_FIRST_EN: simultaneous ev=1010 -> first_id=1, first_valid=1.
